// File: rtl/updown_counter_lim.sv
// Limited up/down counter with load, programmable step, wrap/saturate and sticky crossing flags.
// One-clock latency from en/load to out/tc/ovf/unf. There is no backpressure, and cfg_err is combinational.
module updown_counter_lim #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned STEP_W    = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  lo_lim,
    input  logic [WIDTH-1:0]  hi_lim,
    input  logic              sat_mode,
    input  logic              clr_flags,
    output logic [WIDTH-1:0]  out,
    output logic              tc,
    output logic              ovf,
    output logic              unf,
    output logic              cfg_err
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH:0]   step_x;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   lo_plus;
    logic [WIDTH-1:0] diff;
    logic             count_ok;

    assign cfg_err = (lo_lim > hi_lim);

    // Compare in WIDTH+1 bits so that neither the sum nor lo_lim+step can alias modulo 2^WIDTH.
    assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
    assign sum     = {1'b0, out_q} + step_x;
    assign lo_plus = {1'b0, lo_lim} + step_x;
    assign diff    = out_q - step_x[WIDTH-1:0];

    // A zero step never moves the counter and never counts as a crossing.
    assign count_ok = en && !cfg_err && (step != '0);

    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q & ~clr_flags;
        unf_d = unf_q & ~clr_flags;
        if (load) begin
            out_d = load_val;
        end else if (count_ok) begin
            if (up_down) begin
                if (sum <= {1'b0, hi_lim}) begin
                    out_d = sum[WIDTH-1:0];
                end else begin
                    out_d = sat_mode ? hi_lim : lo_lim;
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                end
            end else begin
                if ({1'b0, out_q} >= lo_plus) begin
                    out_d = diff;
                end else begin
                    out_d = sat_mode ? lo_lim : hi_lim;
                    tc_d  = 1'b1;
                    unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= WIDTH'(RESET_VAL);
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;
    assign unf = unf_q;

endmodule

// File: tb/tb_updown_counter_lim.sv
// Bench for updown_counter_lim: directed scenarios against constants, then random traffic against an arithmetic model.
module tb_updown_counter_lim;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] step;
    logic [7:0] lo_lim;
    logic [7:0] hi_lim;
    logic       sat_mode;
    logic       clr_flags;
    logic [7:0] out;
    logic       tc;
    logic       ovf;
    logic       unf;
    logic       cfg_err;

    int checks = 0;
    int errors = 0;

    int m_out = 0;
    int m_tc  = 0;
    int m_ovf = 0;
    int m_unf = 0;

    updown_counter_lim #(.WIDTH(8), .STEP_W(4), .RESET_VAL(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .step     (step),
        .lo_lim   (lo_lim),
        .hi_lim   (hi_lim),
        .sat_mode (sat_mode),
        .clr_flags(clr_flags),
        .out      (out),
        .tc       (tc),
        .ovf      (ovf),
        .unf      (unf),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference behaviour: integer arithmetic straight from the counting rules.
    task automatic model_edge();
        int lo, hi, s, o;
        lo = int'(lo_lim);
        hi = int'(hi_lim);
        s  = int'(step);
        o  = m_out;
        m_tc = 0;
        if (clr_flags) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (load) begin
            m_out = int'(load_val);
        end else if (en && lo <= hi && s != 0) begin
            if (up_down) begin
                if (o + s <= hi) m_out = o + s;
                else begin m_out = sat_mode ? hi : lo; m_tc = 1; m_ovf = 1; end
            end else begin
                if (o - s >= lo) m_out = o - s;
                else begin m_out = sat_mode ? lo : hi; m_tc = 1; m_unf = 1; end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; load = 0; clr_flags = 0; load_val = 8'd0;
    endtask

    task automatic load_and_clear(input int v);
        idle_inputs();
        load = 1; load_val = 8'(v); clr_flags = 1;
        cycle();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1; up_down = 1; step = 4'd1; lo_lim = 8'd0; hi_lim = 8'd255; sat_mode = 0;
        idle_inputs();
        #2;
        checks++;
        if (out !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: out=%0d tc=%b ovf=%b unf=%b, want 0 0 0 0", out, tc, ovf, unf);
        end
        @(negedge clk);
        reset = 0;
        m_out = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        en = 1;
        cycle();
        cycle();
        checks++;
        if (out !== 8'd2) begin
            errors++;
            $display("FAIL reset_first_counts: out=%0d want 2", out);
        end
        // Force a wrap so that tc and ovf are set, then reset away from any clock edge.
        load = 1; load_val = 8'd255; cycle(); load = 0;
        cycle();
        #2;
        reset = 1;
        #1;
        checks++;
        if (out !== 8'd0 || tc !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out=%0d tc=%b ovf=%b unf=%b, want 0 0 0 0", out, tc, ovf, unf);
        end
        m_out = 0; m_tc = 0; m_ovf = 0; m_unf = 0;
        @(negedge clk);
        reset = 0;
        idle_inputs();
        #1;
    endtask

    task automatic test_load();
        en = 1; up_down = 1; step = 4'd3; load = 1; load_val = 8'h37;
        cycle();
        idle_inputs();
        checks++;
        if (out !== 8'h37 || tc !== 1'b0) begin
            errors++;
            $display("FAIL load_overrides_en: out=%0h tc=%b, want 37 0", out, tc);
        end
    endtask

    task automatic test_wrap_up();
        int exp_out[5] = '{10, 13, 16, 19, 10};
        int exp_tc[5]  = '{1, 0, 0, 0, 1};
        lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd3; sat_mode = 0; up_down = 1;
        load_and_clear(18);
        en = 1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (out !== 8'(exp_out[i]) || tc !== 1'(exp_tc[i]) || ovf !== 1'b1) begin
                errors++;
                $display("FAIL wrap_up[%0d]: out=%0d tc=%b ovf=%b, want %0d %0d 1", i, out, tc, ovf, exp_out[i], exp_tc[i]);
            end
        end
        en = 0;
    endtask

    task automatic test_sat_down();
        lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd4; sat_mode = 1; up_down = 0;
        load_and_clear(13);
        en = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out !== 8'd10 || tc !== 1'b1 || unf !== 1'b1 || ovf !== 1'b0) begin
                errors++;
                $display("FAIL sat_down[%0d]: out=%0d tc=%b unf=%b ovf=%b, want 10 1 1 0", i, out, tc, unf, ovf);
            end
        end
        en = 0;
        cycle();
        checks++;
        if (out !== 8'd10 || tc !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold_en_low: out=%0d tc=%b, want 10 0", out, tc);
        end
    endtask

    task automatic test_full_range();
        lo_lim = 8'd0; hi_lim = 8'd255; step = 4'd1; sat_mode = 0; up_down = 1;
        load_and_clear(255);
        en = 1;
        cycle();
        checks++;
        if (out !== 8'd0 || tc !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_range_up: out=%0d tc=%b ovf=%b, want 0 1 1", out, tc, ovf);
        end
        up_down = 0;
        cycle();
        checks++;
        if (out !== 8'd255 || tc !== 1'b1 || unf !== 1'b1) begin
            errors++;
            $display("FAIL full_range_down: out=%0d tc=%b unf=%b, want 255 1 1", out, tc, unf);
        end
        en = 0;
    endtask

    task automatic test_flag_clear();
        lo_lim = 8'd10; hi_lim = 8'd20; step = 4'd1; sat_mode = 0; up_down = 1;
        load_and_clear(20);
        en = 1; clr_flags = 1;
        cycle();
        checks++;
        if (out !== 8'd10 || tc !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL flag_set_wins: out=%0d tc=%b ovf=%b, want 10 1 1", out, tc, ovf);
        end
        en = 0;
        cycle();
        checks++;
        if (ovf !== 1'b0 || unf !== 1'b0 || tc !== 1'b0) begin
            errors++;
            $display("FAIL flag_clear: ovf=%b unf=%b tc=%b, want 0 0 0", ovf, unf, tc);
        end
        clr_flags = 0;
    endtask

    task automatic test_cfg();
        lo_lim = 8'd30; hi_lim = 8'd20; step = 4'd1; up_down = 1;
        load_and_clear(25);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_high: cfg_err=%b want 1", cfg_err);
        end
        en = 1;
        cycle();
        cycle();
        checks++;
        if (out !== 8'd25 || tc !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_hold: out=%0d tc=%b, want 25 0", out, tc);
        end
        load = 1; load_val = 8'h55;
        cycle();
        load = 0;
        checks++;
        if (out !== 8'h55) begin
            errors++;
            $display("FAIL cfg_err_load: out=%0h want 55", out);
        end
        lo_lim = 8'd0; hi_lim = 8'd255; step = 4'd0;
        #1;
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_low: cfg_err=%b want 0", cfg_err);
        end
        cycle();
        cycle();
        checks++;
        if (out !== 8'h55 || tc !== 1'b0) begin
            errors++;
            $display("FAIL step_zero_hold: out=%0h tc=%b, want 55 0", out, tc);
        end
        en = 0;
    endtask

    task automatic test_random();
        int a, b;
        for (int i = 0; i < 400; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if ($urandom_range(0, 9) != 0 && a > b) begin
                lo_lim = 8'(b); hi_lim = 8'(a);
            end else begin
                lo_lim = 8'(a); hi_lim = 8'(b);
            end
            en        = ($urandom_range(0, 3) != 0);
            up_down   = 1'($urandom_range(0, 1));
            load      = ($urandom_range(0, 7) == 0);
            load_val  = 8'($urandom_range(0, 255));
            step      = 4'($urandom_range(0, 15));
            sat_mode  = 1'($urandom_range(0, 1));
            clr_flags = ($urandom_range(0, 7) == 0);
            cycle();
            checks++;
            if (out !== 8'(m_out) || tc !== 1'(m_tc) || ovf !== 1'(m_ovf) || unf !== 1'(m_unf)
                || cfg_err !== (lo_lim > hi_lim)) begin
                errors++;
                $display("FAIL random[%0d]: out=%0d tc=%b ovf=%b unf=%b cfg=%b, want %0d %0d %0d %0d %b",
                         i, out, tc, ovf, unf, cfg_err, m_out, m_tc, m_ovf, m_unf, (lo_lim > hi_lim));
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap_up();
        test_sat_down();
        test_full_range();
        test_flag_clear();
        test_cfg();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
